// File: rtl/stack_bus_upstream_arbiter_if.sv
// Upstream stack-bus bundle: NUM_PORTS PE-side request lanes plus one shared manager-side lane.
// slave is the arbiter's view; master is the view of the PEs and manager around it.
interface stack_bus_upstream_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNTL_WIDTH = 2
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*CNTL_WIDTH-1:0] req_cntl;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]            req_ready;
  logic                            out_valid;
  logic [CNTL_WIDTH-1:0]           out_cntl;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_ready;

  modport slave (
    input  req_valid, req_cntl, req_data, out_ready,
    output req_ready, out_valid, out_cntl, out_data
  );

  modport master (
    output req_valid, req_cntl, req_data, out_ready,
    input  req_ready, out_valid, out_cntl, out_data
  );
endinterface

// File: rtl/stack_bus_upstream_arbiter.sv
// Packet-granular round-robin arbiter sharing one upstream stack-bus lane between
// NUM_PORTS PE requesters; the manager-side beat is fully registered.
module stack_bus_upstream_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int CNTL_WIDTH    = 2,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_poweron,
  stack_bus_upstream_arbiter_if.slave  bus,
  output logic [PORT_ID_WIDTH-1:0]     grant_id,
  output logic                         busy,
  output logic [15:0]                  pkt_count,
  output logic                         err_protocol
);
  localparam int SOP_BIT = 0;
  localparam int EOP_BIT = 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state_q, state_d;
  logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic                     out_valid_q, out_valid_d;
  logic [CNTL_WIDTH-1:0]    out_cntl_q, out_cntl_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [15:0]              pkt_count_q, pkt_count_d;
  logic                     err_q, err_d;
  logic                     first_beat_q, first_beat_d;

  logic [NUM_PORTS-1:0]     eligible;
  logic [NUM_PORTS-1:0]     bad_start;
  logic                     any_eligible;
  logic [PORT_ID_WIDTH-1:0] rr_winner;
  logic                     sel_valid;
  logic [CNTL_WIDTH-1:0]    sel_cntl;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     lane_free;
  logic                     accept;
  logic [NUM_PORTS-1:0]     req_ready;
  logic [PORT_ID_WIDTH-1:0] next_ptr;

  always_comb begin
    eligible  = '0;
    bad_start = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i]  = bus.req_valid[i] &&  bus.req_cntl[i*CNTL_WIDTH + SOP_BIT];
      bad_start[i] = bus.req_valid[i] && !bus.req_cntl[i*CNTL_WIDTH + SOP_BIT];
    end
  end

  // Walk offsets from farthest to nearest so the port closest to rr_ptr is written last and wins.
  always_comb begin
    any_eligible = 1'b0;
    rr_winner    = rr_ptr_q;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (((int'(rr_ptr_q) + k) % NUM_PORTS) == i && eligible[i]) begin
          any_eligible = 1'b1;
          rr_winner    = PORT_ID_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_cntl  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id_q == PORT_ID_WIDTH'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_cntl  = bus.req_cntl[i*CNTL_WIDTH +: CNTL_WIDTH];
        sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign lane_free = !out_valid_q || bus.out_ready;
  assign accept    = (state_q == XFER) && sel_valid && lane_free;
  assign next_ptr  = (grant_id_q == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                    : grant_id_q + PORT_ID_WIDTH'(1);

  always_comb begin
    req_ready = '0;
    if (state_q == XFER) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_id_q == PORT_ID_WIDTH'(i)) req_ready[i] = lane_free;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    out_valid_d  = out_valid_q;
    out_cntl_d   = out_cntl_q;
    out_data_d   = out_data_q;
    pkt_count_d  = pkt_count_q;
    err_d        = err_q;
    first_beat_d = first_beat_q;

    // The held beat drains in either state; a newly accepted beat overrides this below.
    if (bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bad_start) err_d = 1'b1;
        if (any_eligible) begin
          grant_id_d   = rr_winner;
          first_beat_d = 1'b1;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          out_valid_d  = 1'b1;
          out_cntl_d   = sel_cntl;
          out_data_d   = sel_data;
          first_beat_d = 1'b0;
          if (!first_beat_q && sel_cntl[SOP_BIT]) err_d = 1'b1;
          if (sel_cntl[EOP_BIT]) begin
            state_d     = IDLE;
            rr_ptr_d    = next_ptr;
            pkt_count_d = pkt_count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      out_valid_q  <= 1'b0;
      out_cntl_q   <= '0;
      out_data_q   <= '0;
      pkt_count_q  <= '0;
      err_q        <= 1'b0;
      first_beat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      out_valid_q  <= out_valid_d;
      out_cntl_q   <= out_cntl_d;
      out_data_q   <= out_data_d;
      pkt_count_q  <= pkt_count_d;
      err_q        <= err_d;
      first_beat_q <= first_beat_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cntl  = out_cntl_q;
  assign bus.out_data  = out_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q == XFER);
  assign pkt_count     = pkt_count_q;
  assign err_protocol  = err_q;
endmodule

// File: tb/tb_stack_bus_upstream_arbiter.sv
// Directed bench for stack_bus_upstream_arbiter: per-port source queues feed the DUT and
// a scoreboard of expected output beats (with owning port) is checked at the manager side.
module tb_stack_bus_upstream_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic [PW-1:0] grant_id;
  logic          busy;
  logic [15:0]   pkt_count;
  logic          err_protocol;

  stack_bus_upstream_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CNTL_WIDTH(CW)) bus_if ();

  stack_bus_upstream_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .CNTL_WIDTH(CW), .PORT_ID_WIDTH(PW)
  ) dut (
    .clk          (clk),
    .reset_poweron(reset_poweron),
    .bus          (bus_if),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .err_protocol (err_protocol)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    port;
    logic [CW-1:0] cntl;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         src_q [NP][$];
  beat_t         exp_q [$];
  logic [NP-1:0] acc;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_lines();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        bus_if.req_valid[p]         = 1'b1;
        bus_if.req_cntl[p*CW +: CW] = src_q[p][0].cntl;
        bus_if.req_data[p*DW +: DW] = src_q[p][0].data;
      end else begin
        bus_if.req_valid[p]         = 1'b0;
        bus_if.req_cntl[p*CW +: CW] = '0;
        bus_if.req_data[p*DW +: DW] = '0;
      end
    end
  endtask

  task automatic applyStimulus(input int port, input logic [CW-1:0] cntl,
                               input logic [DW-1:0] data, input bit expect_out);
    beat_t b;
    b.port = 4'(port);
    b.cntl = cntl;
    b.data = data;
    src_q[port].push_back(b);
    if (expect_out) exp_q.push_back(b);
    drive_lines();
  endtask

  // One clock: score the output at negedge, then retire accepted source beats after posedge.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (bus_if.out_valid && bus_if.out_ready) begin
      checkOutput("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out_data", bus_if.out_data, e.data);
        checkOutput("out_cntl", 64'(bus_if.out_cntl), 64'(e.cntl));
        checkOutput("grant_id", 64'(grant_id), 64'(e.port));
      end
    end
    for (int p = 0; p < NP; p++) acc[p] = bus_if.req_valid[p] && bus_if.req_ready[p];
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    end
    drive_lines();
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    drive_lines();
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_poweron = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy || bus_if.out_valid) && n < 200) begin
      step();
      n++;
    end
    checkOutput(tag, 64'({exp_q.size() != 0, busy, bus_if.out_valid}), 64'd0);
  endtask

  task automatic wait_out_data(input string tag, input logic [DW-1:0] data);
    int n = 0;
    while (!(bus_if.out_valid && bus_if.out_data == data) && n < 50) begin
      step();
      n++;
    end
    checkOutput(tag, 64'(bus_if.out_valid && bus_if.out_data == data), 64'd1);
  endtask

  initial begin
    reset_poweron    = 1'b1;
    bus_if.out_ready = 1'b1;
    drive_lines();
    #1;
    checkOutput("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
    checkOutput("rst_out_cntl", 64'(bus_if.out_cntl), 64'd0);
    checkOutput("rst_out_data", bus_if.out_data, 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
    checkOutput("rst_err", 64'(err_protocol), 64'd0);
    do_reset();

    $display("[TB] single-port packet");
    applyStimulus(1, 2'b01, 64'hA0, 1'b1);
    applyStimulus(1, 2'b00, 64'hA1, 1'b1);
    applyStimulus(1, 2'b10, 64'hA2, 1'b1);
    step();
    checkOutput("t1_grant", 64'(grant_id), 64'd1);
    checkOutput("t1_req_ready", 64'(bus_if.req_ready), 64'b0010);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_no_early_valid", 64'(bus_if.out_valid), 64'd0);
    step();
    checkOutput("t1_latency_valid", 64'(bus_if.out_valid), 64'd1);
    checkOutput("t1_first_data", bus_if.out_data, 64'hA0);
    wait_drain("t1_drain");
    checkOutput("t1_pkt_count", 64'(pkt_count), 64'd1);
    checkOutput("t1_grant_hold", 64'(grant_id), 64'd1);
    // rr_ptr is now 2, so port 2 beats port 1
    applyStimulus(2, 2'b11, 64'hA8, 1'b1);
    applyStimulus(1, 2'b11, 64'hA9, 1'b1);
    wait_drain("t1_rr_drain");
    checkOutput("t1_rr_pkt_count", 64'(pkt_count), 64'd3);

    $display("[TB] round-robin fairness");
    do_reset();
    for (int k = 0; k < 4; k++) applyStimulus((k % 2 == 0) ? 0 : 2, 2'b11, 64'hB0 + 64'(k), 1'b1);
    wait_drain("t2_drain");
    checkOutput("t2_pkt_count", 64'(pkt_count), 64'd4);

    $display("[TB] pointer skip");
    do_reset();
    applyStimulus(0, 2'b11, 64'hC0, 1'b1);
    wait_drain("t3_first_drain");
    applyStimulus(3, 2'b11, 64'hC1, 1'b1);
    applyStimulus(0, 2'b11, 64'hC2, 1'b1);
    wait_drain("t3_drain");
    checkOutput("t3_pkt_count", 64'(pkt_count), 64'd3);

    $display("[TB] backpressure");
    do_reset();
    applyStimulus(2, 2'b01, 64'hD0, 1'b1);
    applyStimulus(2, 2'b00, 64'hD1, 1'b1);
    applyStimulus(2, 2'b00, 64'hD2, 1'b1);
    applyStimulus(2, 2'b10, 64'hD3, 1'b1);
    wait_out_data("t4_reach_beat2", 64'hD1);
    bus_if.out_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      checkOutput("t4_stall_ready", 64'(bus_if.req_ready), 64'd0);
      checkOutput("t4_stall_data", bus_if.out_data, 64'hD1);
      checkOutput("t4_stall_valid", 64'(bus_if.out_valid), 64'd1);
      if (s < 2) step();
    end
    bus_if.out_ready = 1'b1;
    wait_drain("t4_drain");
    checkOutput("t4_pkt_count", 64'(pkt_count), 64'd1);

    $display("[TB] reset mid-packet");
    do_reset();
    for (int k = 0; k < 5; k++)
      applyStimulus(1, (k == 0) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00), 64'hE0 + 64'(k), 1'b1);
    wait_out_data("t5_reach_beat2", 64'hE1);
    checkOutput("t5_busy_before", 64'(busy), 64'd1);
    #2;
    reset_poweron = 1'b1;
    #1;
    checkOutput("t5_async_out_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("t5_async_req_ready", 64'(bus_if.req_ready), 64'd0);
    checkOutput("t5_async_busy", 64'(busy), 64'd0);
    checkOutput("t5_async_pkt_count", 64'(pkt_count), 64'd0);
    do_reset();
    applyStimulus(3, 2'b11, 64'hF0, 1'b1);
    wait_drain("t5_drain");
    checkOutput("t5_pkt_count", 64'(pkt_count), 64'd1);
    checkOutput("t5_err", 64'(err_protocol), 64'd0);

    $display("[TB] protocol error in packet");
    do_reset();
    applyStimulus(0, 2'b01, 64'h10, 1'b1);
    applyStimulus(0, 2'b01, 64'h11, 1'b1);
    applyStimulus(0, 2'b10, 64'h12, 1'b1);
    step();
    step();
    checkOutput("t6_beat1_data", bus_if.out_data, 64'h10);
    checkOutput("t6_err_after_beat1", 64'(err_protocol), 64'd0);
    step();
    checkOutput("t6_beat2_data", bus_if.out_data, 64'h11);
    checkOutput("t6_err_after_beat2", 64'(err_protocol), 64'd1);
    wait_drain("t6_drain");
    checkOutput("t6_err_sticky", 64'(err_protocol), 64'd1);
    checkOutput("t6_pkt_count", 64'(pkt_count), 64'd1);

    $display("[TB] protocol error in idle");
    do_reset();
    applyStimulus(2, 2'b00, 64'h55, 1'b0);
    step();
    checkOutput("t7_err", 64'(err_protocol), 64'd1);
    step();
    checkOutput("t7_not_granted", 64'(busy), 64'd0);
    checkOutput("t7_no_ready", 64'(bus_if.req_ready), 64'd0);
    do_reset();
    checkOutput("t7_err_cleared", 64'(err_protocol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stack_bus_upstream_arbiter.md
Name: stack_bus_upstream_arbiter

Overview:
- Shares one manager-side upstream stack-bus lane between NUM_PORTS PE-side upstream requesters.
- Arbitration is round-robin at packet granularity. Once a port is granted, it owns the lane until its end-of-packet (EOP) beat is accepted.
- The output is fully registered, with a valid/ready handshake on both sides.
- Sits between the PE upstream ports and the manager upstream port inside the stack-bus wiring.

Parameters:
- NUM_PORTS, 4, number of PE requesters (2..16).
- DATA_WIDTH, 64, upstream data beat width.
- CNTL_WIDTH, 2, beat control: bit0 = SOP, bit1 = EOP; both set = single-beat packet.
- PORT_ID_WIDTH, 2, width of grant_id; must be >= clog2(NUM_PORTS).

Ports:
- clk  input  1  system clock.
- reset_poweron  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_PORTS  per-port beat valid.
- req_cntl  input  NUM_PORTS*CNTL_WIDTH  per-port beat control; port i at [i*CNTL_WIDTH +: CNTL_WIDTH].
- req_data  input  NUM_PORTS*DATA_WIDTH  per-port beat data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_PORTS  per-port beat accept.
- out_valid  output  1  manager-side beat valid.
- out_cntl  output  CNTL_WIDTH  manager-side beat control.
- out_data  output  DATA_WIDTH  manager-side beat data.
- out_ready  input  1  manager-side accept.
- grant_id  output  PORT_ID_WIDTH  currently or last granted port.
- busy  output  1  high while in XFER.
- pkt_count  output  16  number of completed packets; wraps 0xFFFF -> 0.
- err_protocol  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): state = IDLE; rr_ptr = 0. All outputs are 0: req_ready, out_valid, out_cntl, out_data, grant_id, busy, pkt_count, err_protocol.
- Reset mid-packet: the in-flight packet is dropped, including any beat held in the output register. No partial-packet recovery is attempted.
- Beat transfer rule: a beat transfers on any edge where valid and ready are both high. Data and control must be held stable while valid is high and ready is low.
- Eligibility: port i is eligible when req_valid[i] = 1 and req_cntl[i] bit0 (SOP) = 1.
- IDLE:
  - Search rr_ptr, rr_ptr+1, ... (mod NUM_PORTS) and register the first eligible port as grant_id.
  - Next state is XFER if any port is eligible; otherwise stay in IDLE.
  - req_ready = 0 for all ports.
- XFER:
  - busy = 1.
  - req_ready[grant_id] = (!out_valid || out_ready); req_ready is 0 for all other ports.
  - An accepted beat is loaded into out_cntl/out_data, and out_valid = 1 on the next cycle.
  - out_valid clears when out_ready is high and no new beat is loaded.
  - On acceptance of a beat with EOP set: next state = IDLE, rr_ptr = grant_id+1 (mod NUM_PORTS), pkt_count increments.
- Latency: an eligible request at edge t in IDLE gives req_ready high during cycle t+1. The first beat appears on out_valid one cycle after its acceptance. The first beat after the request therefore appears at cycle t+2 at the earliest.
- Throughput: 1 beat/cycle while out_ready = 1. There is a one-cycle arbitration bubble between packets.
- Backpressure: out_ready = 0 while out_valid = 1 gives req_ready[grant_id] = 0. The output register holds its value.
- Simultaneous requests: the port nearest rr_ptr in ascending modular order wins. Losing ports keep valid asserted, receive no ready, and lose no data.
- Protocol errors (err_protocol set, sticky until reset):
  - An accepted non-first beat in XFER has SOP set. The beat is still forwarded.
  - In IDLE, req_valid[i] = 1 with SOP = 0. The port is not granted, and the flag is set on that cycle.
- grant_id holds its last value in IDLE until the next grant.
- Output mapping: out_cntl and out_data carry the accepted beat's control and data unmodified.

Test Plan:
- Single-port packet: reset, then port 1 sends 3 beats (cntl 01, 00, 10; data 0xA0..0xA2) with out_ready = 1. Required: grant_id = 1, out beats 0xA0, 0xA1, 0xA2 in order, first out_valid 2 cycles after req_valid, pkt_count = 1, back in IDLE, rr_ptr = 2.
- Round-robin fairness: ports 0 and 2 each present a single-beat packet (cntl 11) continuously from reset. Required: grant order 0, 2, 0, 2; never two consecutive grants to one port; pkt_count = 4 after 4 packets.
- Pointer skip: with rr_ptr = 1 (after a port-0 packet), ports 0 and 3 request simultaneously. Required: port 3 is granted first, then port 0.
- Backpressure: a 4-beat packet with out_ready low for 3 cycles after beat 2 is registered. Required: out_data holds beat 2, req_ready = 0 during the stall, no beat is lost or duplicated, all 4 beats delivered.
- Reset mid-packet: assert reset_poweron asynchronously after beat 2 of a 5-beat packet. Required: out_valid, req_ready and busy drop to 0 immediately without a clock edge; pkt_count = 0; after release, a new single-beat packet from port 3 is granted normally.
- Protocol error: port 0 sends beats with cntl 01, 01, 10. Required: err_protocol rises after the second accepted beat and stays high; all 3 beats are forwarded; pkt_count increments by 1.
